// File: rtl/unit_test_hw_pkg.sv
//------------------------------------------------------------------------------
// unit_test_hw_pkg : shared types and helpers for the unit_test result monitor
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package unit_test_hw_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } ut_state_e;

    // Widest supported record fields (32 channels, 32-bit stamps)
    localparam int UT_CH_W = 5;
    localparam int UT_TS_W = 32;

    typedef struct packed {
        logic [UT_CH_W-1:0] ch;
        logic [UT_TS_W-1:0] ts;
    } ut_fail_rec_t;

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/unit_test_fail_fifo.sv
//------------------------------------------------------------------------------
// unit_test_fail_fifo : first-word-fall-through FIFO of failure records
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module unit_test_fail_fifo #(
    parameter int DEPTH = 8,
    parameter int CH_W  = 2,
    parameter int TS_W  = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            push,
    input  logic [CH_W-1:0] push_ch,
    input  logic [TS_W-1:0] push_ts,
    input  logic            pop,
    output logic [CH_W-1:0] head_ch,
    output logic [TS_W-1:0] head_ts,
    output logic            full,
    output logic            empty
);
    localparam int AW = $clog2(DEPTH);

    logic [CH_W+TS_W-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= {push_ch, push_ts};
    end

    assign head_ch = empty ? '0 : mem[rd_ptr][CH_W+TS_W-1:TS_W];
    assign head_ts = empty ? '0 : mem[rd_ptr][TS_W-1:0];

endmodule

`default_nettype wire

// File: rtl/unit_test_result_monitor.sv
//------------------------------------------------------------------------------
// unit_test_result_monitor : pass/fail counting, failure log and run verdict
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module unit_test_result_monitor
    import unit_test_hw_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 16,
    parameter int TS_W       = 20,
    parameter int FIFO_DEPTH = 8,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [TS_W-1:0]   timeout_cycles,
    input  logic [NUM_CH-1:0] ch_valid,
    input  logic [NUM_CH-1:0] ch_pass,
    input  logic [NUM_CH-1:0] ch_done,
    input  logic              fail_pop,
    output logic              fail_valid,
    output logic [CH_W-1:0]   fail_ch,
    output logic [TS_W-1:0]   fail_ts,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic              busy,
    output logic              done,
    output logic              timed_out,
    output logic              passed,
    output logic              overflow
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ut_state_e         state, state_nx;
    logic [TS_W-1:0]   cycle_cnt;
    logic [TS_W-1:0]   timeout_lat;
    logic [NUM_CH-1:0] done_mask, mask_nx;
    logic [NUM_CH-1:0] fails;
    logic [5:0]        n_pass, n_fail;
    logic [CH_W-1:0]   first_idx;
    logic              found, multi_fail;
    logic              in_run, run_start;
    logic              push, push_drop;
    logic              fifo_full, fifo_empty;

    assign in_run     = (state == RUN);
    assign run_start  = start && !in_run;
    assign fails      = ch_valid & ~ch_pass;
    assign multi_fail = (fails & (fails - NUM_CH'(1))) != '0;
    assign push       = in_run && found;
    assign push_drop  = push && fifo_full && !fail_pop;

    always_comb begin
        n_pass    = '0;
        n_fail    = '0;
        first_idx = '0;
        found     = 1'b0;
        // Descending scan so the lowest failing index is the last one written
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_valid[i]) begin
                if (ch_pass[i]) n_pass = n_pass + 6'd1;
                else            n_fail = n_fail + 6'd1;
            end
            if (fails[i]) begin
                found     = 1'b1;
                first_idx = CH_W'(i);
            end
        end
    end

    always_comb begin
        state_nx = state;
        mask_nx  = done_mask | ch_done;
        case (state)
            IDLE, DONE, TIMEOUT: if (start) state_nx = RUN;
            RUN: begin
                if (&mask_nx)
                    state_nx = DONE;
                else if (timeout_lat != '0 && cycle_cnt == timeout_lat)
                    state_nx = TIMEOUT;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cycle_cnt   <= '0;
            timeout_lat <= '0;
            done_mask   <= '0;
            pass_count  <= '0;
            fail_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            state <= state_nx;
            if (run_start) begin
                cycle_cnt   <= '0;
                timeout_lat <= timeout_cycles;
                done_mask   <= '0;
                pass_count  <= '0;
                fail_count  <= '0;
                overflow    <= 1'b0;
            end else if (in_run) begin
                pass_count <= CNT_W'(sat_add(32'(pass_count), 32'(n_pass), 32'(CNT_MAX)));
                fail_count <= CNT_W'(sat_add(32'(fail_count), 32'(n_fail), 32'(CNT_MAX)));
                cycle_cnt  <= (&cycle_cnt) ? cycle_cnt : cycle_cnt + TS_W'(1);
                done_mask  <= mask_nx;
                if (push && (multi_fail || push_drop)) overflow <= 1'b1;
            end
        end
    end

    unit_test_fail_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CH_W  (CH_W),
        .TS_W  (TS_W)
    ) u_fail_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (run_start),
        .push    (push),
        .push_ch (first_idx),
        .push_ts (cycle_cnt),
        .pop     (fail_pop),
        .head_ch (fail_ch),
        .head_ts (fail_ts),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign fail_valid = !fifo_empty;
    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign timed_out  = (state == TIMEOUT);
    assign passed     = done && (fail_count == '0) && !overflow;

endmodule

`default_nettype wire

// File: tb/tb_unit_test_result_monitor.sv
//------------------------------------------------------------------------------
// tb_unit_test_result_monitor : directed table, corner sequences, random run
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_unit_test_result_monitor;
    localparam int NUM_CH = 4, CNT_W = 16, TS_W = 20, FIFO_DEPTH = 8;
    localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2, S_TO = 3;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;
    localparam longint TS_MAX  = (64'd1 << TS_W) - 1;

    logic            clk = 1'b0, rst_n = 1'b0, start = 1'b0, fail_pop = 1'b0;
    logic [TS_W-1:0] timeout_cycles = '0;
    logic [3:0]      ch_valid = '0, ch_pass = '0, ch_done = '0;
    logic            fail_valid, busy, done, timed_out, passed, overflow;
    logic [1:0]      fail_ch;
    logic [TS_W-1:0] fail_ts;
    logic [CNT_W-1:0] pass_count, fail_count;

    unit_test_result_monitor #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TS_W(TS_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .timeout_cycles(timeout_cycles),
        .ch_valid(ch_valid), .ch_pass(ch_pass), .ch_done(ch_done), .fail_pop(fail_pop),
        .fail_valid(fail_valid), .fail_ch(fail_ch), .fail_ts(fail_ts),
        .pass_count(pass_count), .fail_count(fail_count), .busy(busy), .done(done),
        .timed_out(timed_out), .passed(passed), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Reference model: verdict, counts and a queue of failure records
    typedef struct { int ch; int ts; } rec_t;
    rec_t   q[$];
    int     m_state, m_mask, m_ovf;
    longint m_cnt, m_to, m_pass, m_fail;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_state = S_IDLE; m_mask = 0; m_ovf = 0;
        m_cnt = 0; m_to = 0; m_pass = 0; m_fail = 0;
        q.delete();
    endfunction

    task automatic model_step();
        int  fails, lo;
        bit  pop_ok, was_full;
        pop_ok = fail_pop && (q.size() > 0);
        if (m_state == S_RUN) begin
            m_pass = m_pass + $countones(ch_valid & ch_pass);
            m_fail = m_fail + $countones(ch_valid & ~ch_pass);
            if (m_pass > CNT_MAX) m_pass = CNT_MAX;
            if (m_fail > CNT_MAX) m_fail = CNT_MAX;
            fails    = int'(ch_valid & ~ch_pass);
            was_full = (q.size() == FIFO_DEPTH);
            if (pop_ok) void'(q.pop_front());
            if (fails != 0) begin
                lo = 0;
                while (((fails >> lo) & 1) == 0) lo++;
                if ($countones(fails) > 1) m_ovf = 1;
                if (!was_full || pop_ok) q.push_back('{lo, int'(m_cnt)});
                else                     m_ovf = 1;
            end
            m_mask = m_mask | int'(ch_done);
            if (m_mask == 15)                      m_state = S_DONE;
            else if (m_to != 0 && m_cnt == m_to)   m_state = S_TO;
            if (m_cnt < TS_MAX) m_cnt++;
        end else if (start) begin
            m_state = S_RUN; m_mask = 0; m_ovf = 0;
            m_cnt = 0; m_pass = 0; m_fail = 0; m_to = timeout_cycles;
            q.delete();
        end else if (pop_ok) begin
            void'(q.pop_front());
        end
    endtask

    task automatic compare_all();
        chk("fail_valid", fail_valid, q.size() > 0);
        chk("fail_ch", fail_ch, (q.size() > 0) ? q[0].ch : 0);
        chk("fail_ts", fail_ts, (q.size() > 0) ? q[0].ts : 0);
        chk("pass_count", pass_count, m_pass);
        chk("fail_count", fail_count, m_fail);
        chk("busy", busy, m_state == S_RUN);
        chk("done", done, m_state == S_DONE);
        chk("timed_out", timed_out, m_state == S_TO);
        chk("overflow", overflow, m_ovf);
        chk("passed", passed, (m_state == S_DONE) && (m_fail == 0) && (m_ovf == 0));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic s, input logic [3:0] v, input logic [3:0] p,
                         input logic [3:0] d, input logic pop);
        start = s; ch_valid = v; ch_pass = p; ch_done = d; fail_pop = pop;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
            step();
        end
    endtask

    typedef struct {
        logic       st;
        logic [3:0] v, p, d;
        int         pc, fc;
        logic       bz, dn, pz;
    } vec_t;
    vec_t tbl[5];

    initial begin
        model_reset();
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_fail_valid", fail_valid, 0);
        chk("rst_pass_count", pass_count, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Three passes on channel 1, then every channel done at once
        tbl[0] = '{1'b1, 4'h0, 4'h0, 4'h0, 0, 0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 4'h2, 4'h2, 4'h0, 1, 0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 4'h2, 4'h2, 4'h0, 2, 0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 4'h2, 4'h2, 4'h0, 3, 0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 4'h0, 4'h0, 4'hF, 3, 0, 1'b0, 1'b1, 1'b1};
        timeout_cycles = 20'd100;
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].st, tbl[i].v, tbl[i].p, tbl[i].d, 1'b0);
            step();
            chk("t1_pass_count", pass_count, tbl[i].pc);
            chk("t1_fail_count", fail_count, tbl[i].fc);
            chk("t1_busy", busy, tbl[i].bz);
            chk("t1_done", done, tbl[i].dn);
            chk("t1_passed", passed, tbl[i].pz);
        end

        // Two failures in one cycle at stamp 5
        drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b0); step();
        idle(5);
        drive(1'b0, 4'h5, 4'h0, 4'h0, 1'b0); step();
        drive(1'b0, 4'h0, 4'h0, 4'hF, 1'b0); step();
        chk("t2_fail_count", fail_count, 2);
        chk("t2_fail_ch", fail_ch, 0);
        chk("t2_fail_ts", fail_ts, 5);
        chk("t2_overflow", overflow, 1);
        chk("t2_passed", passed, 0);
        chk("t2_done", done, 1);

        // Watchdog expiry, then restart clears counts
        timeout_cycles = 20'd10;
        drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b0); step();
        drive(1'b0, 4'h1, 4'h1, 4'h0, 1'b0); step();
        idle(9);
        chk("t3_busy_at_10", busy, 1);
        idle(1);
        chk("t3_timed_out", timed_out, 1);
        chk("t3_busy", busy, 0);
        drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b0); step();
        chk("t3_restart_busy", busy, 1);
        chk("t3_restart_pass", pass_count, 0);
        drive(1'b0, 4'h0, 4'h0, 4'hF, 1'b0); step();

        // Nine failures into an eight-deep FIFO, then drain it
        timeout_cycles = 20'd0;
        drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b0); step();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 4'h8, 4'h0, 4'h0, 1'b0); step();
        end
        drive(1'b0, 4'h0, 4'h0, 4'hF, 1'b0); step();
        chk("t4_fail_count", fail_count, 9);
        chk("t4_overflow", overflow, 1);
        for (int i = 0; i < 8; i++) begin
            chk("t4_head_valid", fail_valid, 1);
            chk("t4_head_ts", fail_ts, i);
            chk("t4_head_ch", fail_ch, 3);
            drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b1); step();
        end
        chk("t4_drained", fail_valid, 0);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b1); step();

        // Last done pulse lands in the timeout cycle
        timeout_cycles = 20'd10;
        drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b0); step();
        drive(1'b0, 4'h0, 4'h0, 4'h7, 1'b0); step();
        idle(9);
        drive(1'b0, 4'h0, 4'h0, 4'h8, 1'b0); step();
        chk("t5_done", done, 1);
        chk("t5_timed_out", timed_out, 0);

        // Asynchronous reset mid-run with records queued
        timeout_cycles = 20'd0;
        drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b0); step();
        drive(1'b0, 4'h3, 4'h1, 4'h0, 1'b0); step();
        drive(1'b0, 4'h4, 4'h0, 4'h0, 1'b0); step();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_fail_valid", fail_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_pass_count", pass_count, 0);
        chk("t6_fail_count", fail_count, 0);
        chk("t6_fail_ts", fail_ts, 0);
        chk("t6_overflow", overflow, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        chk("t6_stays_idle", busy, 0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [3:0] d;
            d = ($urandom_range(0, 9) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
            timeout_cycles = 20'($urandom_range(0, 60));
            drive(($urandom_range(0, 29) == 0), 4'($urandom), 4'($urandom), d,
                  $urandom_range(0, 1) == 1);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/unit_test_result_monitor.md
Name: unit_test_result_monitor

Overview:
- Hardware-side companion to the unit_test framework. Collects per-cycle pass/fail results from NUM_CH DUT checker channels and keeps saturating pass/fail counts.
- Queues a record for each failure (channel and cycle stamp) in a FIFO that the testbench logger drains.
- Decides the run verdict: all channels done, or watchdog timeout.
- Sits between the DUT-side checkers and the SV test runner, which polls its status.

Parameters:
- NUM_CH, 4, number of result channels (1..32).
- CNT_W, 16, width of the pass/fail counters.
- TS_W, 20, width of the cycle counter, the timeout value and the failure timestamps.
- FIFO_DEPTH, 8, number of failure records held (power of 2, >=2).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse that begins or restarts a run.
- timeout_cycles  in  TS_W  watchdog limit, sampled on start; 0 disables the watchdog.
- ch_valid  in  NUM_CH  per-channel result strobe.
- ch_pass  in  NUM_CH  per-channel result, qualified by ch_valid (1 = pass).
- ch_done  in  NUM_CH  per-channel completion pulse.
- fail_pop  in  1  consumer pop of the head failure record.
- fail_valid  out  1  FIFO not empty.
- fail_ch  out  $clog2(NUM_CH) (min 1)  channel of the head record.
- fail_ts  out  TS_W  cycle stamp of the head record.
- pass_count  out  CNT_W  saturating pass total.
- fail_count  out  CNT_W  saturating fail total.
- busy  out  1  state is RUN.
- done  out  1  state is DONE.
- timed_out  out  1  state is TIMEOUT.
- passed  out  1  done && fail_count==0 && !overflow.
- overflow  out  1  sticky: at least one failure record was dropped.

Behaviour:
- Reset (async assert, sync deassert to clk):
  - state=IDLE.
  - All counters, done mask, FIFO pointers and overflow cleared.
  - Every output 0.
- FSM states: IDLE, RUN, DONE, TIMEOUT.
  - IDLE --start--> RUN.
  - RUN --all done_mask bits set--> DONE.
  - RUN --cycle counter == timeout_lat (and timeout_lat != 0)--> TIMEOUT.
  - DONE/TIMEOUT --start--> RUN.
  - start while in RUN is ignored.
- On entry to RUN from start:
  - Clear pass/fail counts, cycle counter, done_mask, FIFO and overflow.
  - Latch timeout_cycles into timeout_lat.
  - Channel inputs in the start cycle are ignored.
- In RUN, the cycle counter increments every cycle and saturates at all-ones.
- Counting: pass_count += popcount(ch_valid & ch_pass) and fail_count += popcount(ch_valid & ~ch_pass) in the same cycle. Both saturate at 2^CNT_W-1. Outputs update one cycle after the strobe.
- done_mask |= ch_done each RUN cycle. A channel may still report results after its done pulse; those are counted.
- Completion check uses the updated mask: the cycle after the last done pulse, state=DONE.
- Done and timeout in the same cycle: DONE wins.
- Results arriving in the cycle the FSM leaves RUN are counted. Nothing is counted outside RUN.
- Failure records:
  - At most one push per cycle: the lowest-index failing channel, with fail_ts = current cycle counter.
  - Any additional failing channels in that cycle set overflow; they are still counted.
  - Push while full with no pop sets overflow and drops the record.
  - Push and pop in the same cycle while full succeed.
  - Pop while empty is ignored.
  - FIFO is first-word-fall-through: fail_ch/fail_ts are valid whenever fail_valid=1. Pointers wrap modulo FIFO_DEPTH.
  - The FIFO remains poppable in DONE/TIMEOUT/IDLE.
- timed_out and done are level outputs held until the next start or reset.

Decomposition:
- Shared package unit_test_hw_pkg holds:
  - ut_state_e enum {IDLE, RUN, DONE, TIMEOUT}.
  - ut_fail_rec_t struct {ch, ts}, parametrised via localparam widths.
  - Saturating-add function.
- One sub-module: unit_test_fail_fifo, a FWFT FIFO of ut_fail_rec_t with push/pop/full/empty and a registered count.

Test Plan:
1. NUM_CH=4, timeout 100, start. Channel 1 gives 3 passes; then ch_done=4'b1111 in one cycle -> pass_count=3, fail_count=0, done=1 and passed=1 the cycle after the done pulse.
2. Channels 0 and 2 fail in the same cycle at cycle stamp 5 -> fail_count=2, one record {ch=0, ts=5}, overflow=1, passed=0 at DONE.
3. timeout_cycles=10, no done pulses -> timed_out=1 when the counter reaches 10, busy=0; a subsequent start clears counts and returns busy=1.
4. 9 single failures on channel 3 with FIFO_DEPTH=8 and no pop -> 8 records, overflow=1, fail_count=9. Popping 8 times returns ts in ascending order, then fail_valid=0.
5. Done pulse for the last channel in the same cycle the timeout is reached -> done=1, timed_out=0.
6. Assert rst_n low mid-RUN with records queued -> all outputs 0 immediately (asynchronous); start is required to run again.
